uart_tx_dev: RTL

Memory-mapped UART transmitter device on the hardware side of the system bridge, a peer of the timer devices. The CPU writes bytes through the bridge into an 8-entry FIFO, and the block serialises them on `txd` as 8N1 frames at a programmable clock divisor. `IntReq` is raised when the transmitter has drained, so software can refill it.

---
 rtl/uart_tx_dev.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a small FIFO that
// the TX FSM serialises on txd at a programmable clk-cycles-per-bit divisor.
module uart_tx_dev #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  HardAddr,
  input  logic [31:0] HardWD,
  input  logic        WeHard,
  output logic [31:0] HardRD,
  output logic        IntReq,
  output logic        txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          txen_q, txen_d;
  logic          ie_q, ie_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          txd_q, txd_d;

  logic        wr_ctrl, wr_data, wr_div;
  logic        push, pop;
  logic        busy, empty, full;
  logic [15:0] reload;
  logic [7:0]  count_ext;
  logic        unused_wd;

  assign wr_ctrl = WeHard && (HardAddr == 2'd0);
  assign wr_data = WeHard && (HardAddr == 2'd2);
  assign wr_div  = WeHard && (HardAddr == 2'd3);

  assign busy  = (state_q != S_IDLE);
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // A zero divisor behaves as one cycle per bit; counter counts down to zero.
  assign reload = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

  assign pop  = (state_q == S_IDLE) && txen_q && !empty;
  assign push = wr_data && (!full || pop);

  assign count_ext = 8'(count_q);
  assign unused_wd = ^HardWD[31:16];

  always_comb begin
    state_d   = state_q;
    txen_d    = txen_q;
    ie_d      = ie_q;
    ovf_d     = ovf_q;
    div_d     = div_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    txd_d     = txd_q;

    if (wr_ctrl) begin
      txen_d = HardWD[0];
      ie_d   = HardWD[1];
      ovf_d  = 1'b0;
    end
    if (wr_data && !push) begin
      ovf_d = 1'b1;
    end
    if (wr_div) begin
      div_d = HardWD[15:0];
    end

    if (push) begin
      mem_d[wr_ptr_q] = HardWD[7:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // txd_d is the line level for the cycle after this edge, so it always
    // reflects the bit the FSM is about to hold.
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = reload;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d     = reload;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          txd_d     = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = reload;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      txen_q    <= 1'b0;
      ie_q      <= 1'b0;
      ovf_q     <= 1'b0;
      div_q     <= DIV_RESET;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      cnt_q     <= 16'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      txen_q    <= txen_d;
      ie_q      <= ie_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      txd_q     <= txd_d;
    end
  end

  always_comb begin
    HardRD = 32'd0;
    case (HardAddr)
      2'd0:    HardRD = {30'd0, ie_q, txen_q};
      2'd1:    HardRD = {24'd0, count_ext[3:0], ovf_q, full, empty, busy};
      2'd3:    HardRD = {16'd0, div_q};
      default: HardRD = 32'd0;
    endcase
  end

  assign IntReq = ie_q && empty && !busy;
  assign txd    = txd_q;

endmodule
